// File: rtl/product_bcd_display_if.sv
// Capture/result bus between the multiplier side and the BCD display block.
interface product_bcd_display_if;
  logic        load;
  logic [15:0] product_in;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;

  modport master (output load, product_in, input busy, bcd_valid, bcd_out);
  modport slave  (input load, product_in, output busy, bcd_valid, bcd_out);
endinterface

// File: rtl/product_bcd_display.sv
// Captures a 16-bit product, converts it to 5 BCD digits by sequential double-dabble,
// and scans the digits onto one 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module product_bcd_display #(
  parameter int SCAN_DIV = 1024
) (
  input  logic                 clk,
  input  logic                 reset_a,
  product_bcd_display_if.slave bus,
  output logic [4:0]           digit_en,
  output logic                 seg_a,
  output logic                 seg_b,
  output logic                 seg_c,
  output logic                 seg_d,
  output logic                 seg_e,
  output logic                 seg_f,
  output logic                 seg_g
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_ZERO = 7'b1111110;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state_q;
  logic [15:0] shreg_q;
  logic [19:0] scratch_q;
  logic [3:0]  bitcnt_q;
  logic        busy_q;
  logic        bcd_valid_q;
  logic [19:0] bcd_out_q;
  logic [19:0] adj_scratch;
  logic [19:0] scratch_d;
  logic [15:0] shreg_d;

  // Add-3 correction on every nibble before each shift
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign adj_scratch[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                      ? scratch_q[gi*4 +: 4] + 4'd3
                                      : scratch_q[gi*4 +: 4];
    end
  endgenerate

  assign scratch_d = {adj_scratch[18:0], shreg_q[15]};
  assign shreg_d   = {shreg_q[14:0], 1'b0};

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      scratch_q   <= '0;
      bitcnt_q    <= '0;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      bcd_out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            shreg_q     <= bus.product_in;
            scratch_q   <= '0;
            bitcnt_q    <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_q <= scratch_d;
          shreg_q   <= shreg_d;
          bitcnt_q  <= bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd15) begin
            bcd_out_q   <= scratch_d;
            bcd_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.bcd_out   = bcd_out_q;

  // Display scan: free-running prescaler and digit index, independent of conversion
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [4:0]    digit_en_q;
  logic [6:0]    seg_q;
  logic          wrap;
  logic [4:0]    show;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_next;

  assign wrap = (presc_q == PW'(SCAN_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
  generate
    for (gi = 0; gi < 5; gi++) begin : g_show
      assign show[gi] = (gi == 0) || (|bcd_out_q[19:gi*4]);
    end
  endgenerate
`else
  assign show = 5'b11111;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    cur_digit = bcd_out_q[{idx_q, 2'b00} +: 4];
    seg_next  = 7'b0000000;
    if (show[idx_q]) seg_next = seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      presc_q    <= '0;
      idx_q      <= '0;
      digit_en_q <= 5'b00001;
      seg_q      <= SEG_ZERO;
    end else begin
      presc_q <= wrap ? '0 : presc_q + 1'b1;
      if (wrap) idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      digit_en_q <= 5'b00001 << idx_q;
      seg_q      <= seg_next;
    end
  end

  assign digit_en = digit_en_q;
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;
endmodule

// File: tb/tb_product_bcd_display.sv
// Scoreboard bench for product_bcd_display: conversions, ignored loads, scan and reset.
module tb_product_bcd_display;
  logic       clk = 1'b0;
  logic       reset_a = 1'b0;
  logic [4:0] digit_en;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  product_bcd_display_if bus();

  product_bcd_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset_a(reset_a), .bus(bus), .digit_en(digit_en),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
  );

  always #5 clk = ~clk;

  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [6:0] segs();
    return {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each new completed result, pop and compare value and busy duration
  logic prev_valid = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (!reset_a) begin
      prev_valid = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.bcd_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.bcd_out), 32'hFFFFFFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          $display("result bcd_out=%05h expected=%05h busy_cycles=%0d", bus.bcd_out, e, busy_cnt);
          check("bcd_out", 32'(bus.bcd_out), 32'(e));
          check("busy_cycles", busy_cnt, 16);
        end
        busy_cnt = 0;
      end
      prev_valid = bus.bcd_valid;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [15:0] val, input logic [19:0] exp);
    @(negedge clk);
    bus.product_in = val;
    bus.load = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd_out"}, 32'(bus.bcd_out), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_valid"}, 32'(bus.bcd_valid), 32'h0);
    check({tag, "_digit_en"}, 32'(digit_en), 32'h1);
    check({tag, "_segs"}, 32'(segs()), 32'h7E);
  endtask

  logic [6:0] seg_exp [5];
  initial begin
    seg_exp[0] = 7'b1111110;
    seg_exp[1] = 7'b1011011;
`ifdef LEADING_ZERO_BLANK_EN
    seg_exp[2] = 7'b0000000;
    seg_exp[3] = 7'b0000000;
    seg_exp[4] = 7'b0000000;
`else
    seg_exp[2] = 7'b1111110;
    seg_exp[3] = 7'b1111110;
    seg_exp[4] = 7'b1111110;
`endif
  end

  initial begin
    bus.load = 1'b0;
    bus.product_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_a = 1'b1;

    issue(16'd0, 20'h00000);      wait_done();
    issue(16'd65025, 20'h65025);  wait_done();

    // Load arriving mid-conversion must be ignored; result holds previous value meanwhile
    issue(16'd7, 20'h00007);
    repeat (3) @(negedge clk);
    check("hold_bcd_out", 32'(bus.bcd_out), 32'h65025);
    check("hold_busy", 32'(bus.busy), 32'h1);
    bus.product_in = 16'd21;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    wait_done();
    issue(16'd21, 20'h00021);     wait_done();
    issue(16'd50, 20'h00050);     wait_done();

    // Scan: sync to the start of digit 0, then walk one full rotation
    begin
      logic [4:0] prev_en;
      int n;
      bit found;
      prev_en = digit_en;
      found = 0;
      n = 0;
      while (!found && n < 40) begin
        @(negedge clk);
        n++;
        if (digit_en == 5'b00001 && prev_en != 5'b00001) found = 1;
        prev_en = digit_en;
      end
      check("scan_sync", 32'(found), 32'h1);
      if (found) begin
        for (int s = 0; s < 20; s++) begin
          check($sformatf("scan_en_%0d", s), 32'(digit_en), 32'(5'b00001 << (s / 4)));
          check($sformatf("scan_seg_%0d", s), 32'(segs()), 32'(seg_exp[s / 4]));
          @(negedge clk);
        end
      end
    end

    // Asynchronous reset in the middle of a conversion
    issue(16'd1234, 20'h01234);
    repeat (6) @(negedge clk);
    #2 reset_a = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("midrun_reset");
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_valid", 32'(bus.bcd_valid), 32'h0);
    check("post_reset_busy", 32'(bus.busy), 32'h0);
    check("post_reset_bcd", 32'(bus.bcd_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
Downstream consumer of the 8x8 multiplier's 16-bit product. It captures product8_8 when the multiplier's done_flag pulses. A sequential double-dabble converter turns the value into 5 BCD digits over 16 clocks. The digits are then time-multiplexed onto one common 7-segment display (seg_a..seg_g plus one-hot digit enables), replacing the single-digit static decode.

Parameters:
SCAN_DIV, 1024, clock cycles each digit is held active before the scan advances; legal range >= 1.

Ports:
clk  input  1  system clock, rising-edge.
reset_a  input  1  asynchronous active-low reset.
load  input  1  capture request, driven by multiplier done_flag; level sampled on rising edge.
product_in  input  16  unsigned product from multiplier (product8_8).
busy  output  1  high while a conversion is in progress.
bcd_valid  output  1  high when bcd_out holds a completed conversion.
bcd_out  output  20  5 BCD digits; [3:0] units ... [19:16] ten-thousands.
digit_en  output  5  one-hot digit select, active-high; bit0 = units.
seg_a..seg_g  output  1 each  segment drives for the selected digit, active-high.

Behaviour:
- Reset (reset_a=0, async, any state):
  - state IDLE, busy=0, bcd_valid=0, bcd_out=0.
  - Scan prescaler=0, digit index=0, digit_en=5'b00001.
  - Segments show "0": a..f=1, g=0.
- Conversion FSM, two states:
  - IDLE: on an edge with load=1:
    - capture product_in into a 16-bit shift register; clear the 20-bit BCD scratch; bit counter=0.
    - clear bcd_valid; set busy=1; go to CONVERT.
  - CONVERT: each clock, add 3 to every scratch nibble >=5, then shift {scratch, shreg} left by 1.
    - On the 16th shift: bcd_out<=final scratch, bcd_valid<=1, busy<=0, go to IDLE.
- Latency: load sampled at edge N -> busy high after N through the edge at N+16. bcd_out/bcd_valid update at edge N+16.
- load while CONVERT: ignored, no restart, no queue. load held high in IDLE restarts a conversion every 17 cycles.
- bcd_out holds the previous result throughout a conversion. The display never shows partial values.
- bcd_valid stays high until the next accepted load.
- Scan:
  - The prescaler free-runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0->1->2->3->4->0 and digit_en = one-hot(index).
  - SCAN_DIV=1 advances every clock.
  - The scan is independent of the FSM.
- Segment decode, registered with digit_en (one cycle after index change, both aligned), from bcd_out digit[index]:
  - 0-9 use standard patterns (e.g. 5 -> a,c,d,f,g=1).
  - Codes 10-15 never occur legally; decode as all segments 0.
- Max input 65535 -> 20'h65535; no overflow possible.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: every digit above the most-significant nonzero digit is blanked (segments all 0). digit_en still cycles normally. Digit 0 is never blanked, so value 0 shows "0" and 50 shows " 50" on digits 1,0 only.
- Undefined: all 5 digits are displayed including leading zeros.

Test Plan:
1. reset_a=0 mid-run -> bcd_out=0, busy=0, bcd_valid=0, digit_en=00001, seg a..f=1, g=0.
2. product_in=16'd50 (10x5), 1-cycle load -> busy high exactly 16 cycles, then bcd_out=20'h00050, bcd_valid=1.
3. product_in=16'd65025 (255x255) -> bcd_out=20'h65025 after 16 cycles; product_in=0 -> 20'h00000.
4. With 21 on the port: load=1 at cycle 5 of a conversion of 7 is ignored and the result is 20'h00007. A new load of 21 in IDLE then gives 20'h00021.
5. SCAN_DIV=4, bcd_out=20'h00050:
   - digit_en steps 00001->00010->00100->01000->10000->00001, every 4 cycles.
   - On 00010, segs show "5" (a,c,d,f,g=1, b,e=0).
   - On 00001, segs show "0".
6. reset_a low at 8th CONVERT cycle -> immediate reset outputs, bcd_valid stays 0. LEADING_ZERO_BLANK_EN build with 50: digits 2-4 all segments 0.
